// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory request arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   OWNER_IF/D  : owner encoding of the granted port (0 = fetch, 1 = data)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_D  = 1'b1;

endpackage

// File: rtl/mem_arb_rr2.sv
// -----------------------------------------------------------------------------
// mem_arb_rr2
// Two-way round-robin pick. Purely combinational.
// Ports:
//   i_req       in  [1:0] request vector, bit 0 = fetch port, bit 1 = data port
//   i_last_gnt  in        owner of the most recently completed transaction
//   o_gnt_vld   out       at least one request present
//   o_gnt_owner out       winning port (valid when o_gnt_vld)
// -----------------------------------------------------------------------------
module mem_arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_gnt,
   output logic       o_gnt_vld,
   output logic       o_gnt_owner
);

   always_comb begin
      o_gnt_vld   = |i_req;
      o_gnt_owner = OWNER_IF;
      case (i_req)
         2'b01:   o_gnt_owner = OWNER_IF;
         2'b10:   o_gnt_owner = OWNER_D;
         // Contention: the port that did not win last time goes next.
         2'b11:   o_gnt_owner = ~i_last_gnt;
         default: o_gnt_owner = OWNER_IF;
      endcase
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
// Round-robin arbiter between an instruction-fetch port (read only) and a
// data port (read/write) in front of a single memory-system interface.
// One transaction at a time; the request is captured at grant and held on
// the memory interface until mem_done. Hit/miss counters and a sticky
// watchdog for transactions that stay in BUSY too long.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_done)
//   if_done/if_rdata         fetch completion pulse and read data
//   d_req/d_wr/d_addr/d_wdata  data request (held until d_done)
//   d_done/d_rdata           data completion pulse and read data
//   mem_addr/mem_wdata/mem_rd/mem_wr   to memory system
//   mem_rdata/mem_done/mem_stall/mem_hit  from memory system
//   hit_cnt/miss_cnt         saturating completion counters
//   err_timeout              sticky watchdog flag
// -----------------------------------------------------------------------------
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [AW-1:0]    if_addr,
   output logic             if_done,
   output logic [DW-1:0]    if_rdata,
   input  logic             d_req,
   input  logic             d_wr,
   input  logic [AW-1:0]    d_addr,
   input  logic [DW-1:0]    d_wdata,
   output logic             d_done,
   output logic [DW-1:0]    d_rdata,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   output logic             mem_rd,
   output logic             mem_wr,
   input  logic [DW-1:0]    mem_rdata,
   input  logic             mem_done,
   input  logic             mem_stall,
   input  logic             mem_hit,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt,
   output logic             err_timeout
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
      return (&v) ? v : v + WAIT_W'(1);
   endfunction

   arb_state_t        r_state;
   logic              r_owner;
   logic              r_last_gnt;
   logic              r_rd;
   logic              r_wr;
   logic [AW-1:0]     r_addr;
   logic [DW-1:0]     r_wdata;
   logic [CNT_W-1:0]  r_hit_cnt;
   logic [CNT_W-1:0]  r_miss_cnt;
   logic [WAIT_W-1:0] r_wait;
   logic              r_err;

   logic [1:0]        w_req;
   logic              w_gnt_vld;
   logic              w_gnt_owner;
   logic              w_done;
   logic [WAIT_W-1:0] w_wait_inc;

   assign w_req      = {d_req, if_req};
   assign w_wait_inc = sat_inc_wait(r_wait);

   mem_arb_rr2 u_rr2 (
      .i_req       (w_req),
      .i_last_gnt  (r_last_gnt),
      .o_gnt_vld   (w_gnt_vld),
      .o_gnt_owner (w_gnt_owner)
   );

   // mem_done is only meaningful while a transaction is outstanding.
   assign w_done   = (r_state == BUSY) && mem_done;
   assign if_done  = w_done && (r_owner == OWNER_IF);
   assign d_done   = w_done && (r_owner == OWNER_D);
   assign if_rdata = if_done ? mem_rdata : '0;
   assign d_rdata  = d_done  ? mem_rdata : '0;

   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign mem_rd      = r_rd;
   assign mem_wr      = r_wr;
   assign hit_cnt     = r_hit_cnt;
   assign miss_cnt    = r_miss_cnt;
   assign err_timeout = r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_owner    <= OWNER_IF;
         r_last_gnt <= OWNER_D;   // so the fetch port wins the first tie
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_wait     <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!mem_stall && w_gnt_vld) begin
                  r_state <= BUSY;
                  r_owner <= w_gnt_owner;
                  r_wait  <= '0;
                  if (w_gnt_owner == OWNER_IF) begin
                     r_addr  <= if_addr;
                     r_wdata <= '0;
                     r_rd    <= 1'b1;
                     r_wr    <= 1'b0;
                  end else begin
                     r_addr  <= d_addr;
                     r_wdata <= d_wdata;
                     r_rd    <= ~d_wr;
                     r_wr    <= d_wr;
                  end
               end
            end
            BUSY: begin
               // Every BUSY cycle counts, including the completing one.
               r_wait <= w_wait_inc;
               if (w_wait_inc == WAIT_W'(TIMEOUT))
                  r_err <= 1'b1;
               if (mem_done) begin
                  r_state    <= IDLE;
                  r_rd       <= 1'b0;
                  r_wr       <= 1'b0;
                  r_last_gnt <= r_owner;
                  if (mem_hit)
                     r_hit_cnt  <= sat_inc_cnt(r_hit_cnt);
                  else
                     r_miss_cnt <= sat_inc_cnt(r_miss_cnt);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
// Directed bench for mem_req_arbiter. A small behavioural memory system sits
// behind the arbiter: first touch of an address is a miss (5 BUSY cycles),
// later touches hit (2 BUSY cycles); writes update the backing store.
// -----------------------------------------------------------------------------
module tb_mem_req_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic        if_done;
   logic [15:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic        d_done;
   logic [15:0] d_rdata;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_rdata = '0;
   logic        mem_done = 1'b0;
   logic        mem_stall = 1'b0;
   logic        mem_hit = 1'b0;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;
   logic        err_timeout;

   int errors = 0;
   int checks = 0;

   mem_req_arbiter #(.AW(16), .DW(16), .CNT_W(16), .TIMEOUT(24)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Behavioural memory system, updated on the falling edge.
   logic [15:0] store  [bit [15:0]];
   bit          cached [bit [15:0]];
   bit          block_done = 1'b0;
   int          resp_cnt = 0;
   int          resp_target = 0;
   bit          resp_hit = 1'b0;

   always @(negedge clk) begin
      mem_done  = 1'b0;
      mem_hit   = 1'b0;
      mem_rdata = '0;
      if (!rst) begin
         resp_cnt = 0;
      end else if (mem_rd || mem_wr) begin
         resp_cnt++;
         if (resp_cnt == 1) begin
            resp_hit    = cached.exists(mem_addr);
            resp_target = resp_hit ? 2 : 5;
         end
         if (resp_cnt >= resp_target && !block_done) begin
            mem_done  = 1'b1;
            mem_hit   = resp_hit;
            mem_rdata = store.exists(mem_addr) ? store[mem_addr] : 16'h0000;
            if (mem_wr) store[mem_addr] = mem_wdata;
            cached[mem_addr] = 1'b1;
            resp_cnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic apply_reset;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Issue one fetch; lat counts falling edges from request to done.
   task automatic run_if(input logic [15:0] a, output logic [15:0] rd,
                         output int lat, output bit got, output int other);
      got = 1'b0; lat = 0; other = 0; rd = '0;
      @(posedge clk); #1;
      if_addr = a;
      if_req  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         lat++;
         if (d_done) other++;
         if (if_done) begin
            got = 1'b1;
            rd  = if_rdata;
            break;
         end
      end
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic run_d(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output bit got, output int other);
      got = 1'b0; other = 0; rd = '0;
      @(posedge clk); #1;
      d_wr = wr; d_addr = a; d_wdata = wd;
      d_req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (if_done) other++;
         if (d_done) begin
            got = 1'b1;
            rd  = d_rdata;
            break;
         end
      end
      @(posedge clk); #1;
      d_req = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
      checks++; if (hit_cnt !== 16'd0) begin errors++; $display("FAIL reset_hit_cnt: got %0d want 0", hit_cnt); end
      checks++; if (miss_cnt !== 16'd0) begin errors++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
      checks++; if ({if_done, d_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {if_done, d_done}); end
   endtask

   task automatic test_write_read;
      logic [15:0] rd;
      bit got;
      int other, lat;
      run_d(1'b1, 16'h0040, 16'hBEEF, rd, got, other);
      checks++; if (!got) begin errors++; $display("FAIL wr_d_done: got no pulse want pulse"); end
      checks++; if (other !== 0) begin errors++; $display("FAIL wr_if_done_spurious: got %0d want 0", other); end
      run_if(16'h0040, rd, lat, got, other);
      checks++; if (!got || rd !== 16'hBEEF) begin errors++; $display("FAIL rd_if_rdata: got %h (done=%b) want beef", rd, got); end
      checks++; if (other !== 0) begin errors++; $display("FAIL rd_d_done_spurious: got %0d want 0", other); end
      @(negedge clk); #1;
      checks++; if (if_rdata !== 16'h0000) begin errors++; $display("FAIL rdata_idle_zero: got %h want 0000", if_rdata); end
      checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL wr_rd_miss_cnt: got %0d want 1", miss_cnt); end
      checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL wr_rd_hit_cnt: got %0d want 1", hit_cnt); end
   endtask

   task automatic test_stall;
      int rd_seen = 0;
      bit got = 1'b0;
      logic [15:0] rd = '0;
      mem_stall = 1'b1;
      @(posedge clk); #1;
      if_addr = 16'h0040;
      if_req  = 1'b1;
      repeat (4) begin
         @(negedge clk); #1;
         if (mem_rd || mem_wr) rd_seen++;
      end
      checks++; if (rd_seen !== 0) begin errors++; $display("FAIL stall_no_grant: got %0d busy cycles want 0", rd_seen); end
      mem_stall = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (if_done) begin got = 1'b1; rd = if_rdata; break; end
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      checks++; if (!got || rd !== 16'hBEEF) begin errors++; $display("FAIL stall_release_rdata: got %h (done=%b) want beef", rd, got); end
   endtask

   task automatic test_both_req;
      logic [3:0] order = '0;
      logic [3:0] exp_order = 4'b1010;   // bit n = owner of n-th completion
      int n = 0;
      int both = 0;
      int addr_err = 0;
      if_addr = 16'h0300;
      d_addr  = 16'h0200;
      d_wr    = 1'b0;
      if_req  = 1'b1;
      d_req   = 1'b1;
      apply_reset();
      for (int i = 0; i < 200 && n < 4; i++) begin
         @(negedge clk); #1;
         if (if_done && d_done) both++;
         if (if_done) begin
            if (mem_addr !== 16'h0300) addr_err++;
            order[n] = 1'b0; n++;
         end else if (d_done) begin
            if (mem_addr !== 16'h0200) addr_err++;
            order[n] = 1'b1; n++;
         end
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      d_req  = 1'b0;
      checks++; if (n !== 4) begin errors++; $display("FAIL rr_completions: got %0d want 4", n); end
      checks++; if (order !== exp_order) begin errors++; $display("FAIL rr_order: got %b want %b", order, exp_order); end
      checks++; if (both !== 0) begin errors++; $display("FAIL rr_both_done: got %0d want 0", both); end
      checks++; if (addr_err !== 0) begin errors++; $display("FAIL rr_owner_addr: got %0d wrong want 0", addr_err); end
   endtask

   task automatic test_drop_req;
      bit seen = 1'b0;
      int pulses = 0;
      int held_err = 0;
      logic [15:0] done_addr = '0;
      logic [15:0] done_wdata = '0;
      logic        done_wr = 1'b0;
      logic [15:0] rd;
      bit got;
      int lat, other;
      @(posedge clk); #1;
      d_wr = 1'b1; d_addr = 16'h0500; d_wdata = 16'h1234;
      d_req = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk); #1;
         if (mem_wr) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL drop_grant: got no mem_wr want mem_wr=1"); end
      @(posedge clk); #1;
      d_req = 1'b0; d_addr = 16'hFFFF; d_wdata = 16'h0000; d_wr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (d_done) begin
            pulses++;
            done_addr = mem_addr; done_wdata = mem_wdata; done_wr = mem_wr;
         end else if (pulses == 0 && mem_wr !== 1'b1) held_err++;
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL drop_done_pulses: got %0d want 1", pulses); end
      checks++; if (held_err !== 0) begin errors++; $display("FAIL drop_wr_held: got %0d low cycles want 0", held_err); end
      checks++; if ({done_addr, done_wdata} !== {16'h0500, 16'h1234} || done_wr !== 1'b1)
         begin errors++; $display("FAIL drop_regs_held: got addr=%h wdata=%h wr=%b want 0500 1234 1", done_addr, done_wdata, done_wr); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL drop_wr_release: got %b want 0", mem_wr); end
      run_if(16'h0500, rd, lat, got, other);
      checks++; if (!got || rd !== 16'h1234) begin errors++; $display("FAIL drop_readback: got %h (done=%b) want 1234", rd, got); end
   endtask

   task automatic test_repeat_hits;
      logic [15:0] rd;
      bit got;
      int lat, other;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         run_if(16'h0100, rd, lat, got, other);
         // lat includes the one IDLE cycle before the grant
         if (k == 0) begin
            checks++; if (!got || lat - 1 !== 5) begin errors++; $display("FAIL rep_miss_latency: got %0d (done=%b) want 5", lat - 1, got); end
         end else begin
            checks++; if (!got || lat - 1 > 2) begin errors++; $display("FAIL rep_hit_latency_%0d: got %0d (done=%b) want <=2", k, lat - 1, got); end
         end
      end
      checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL rep_miss_cnt: got %0d want 1", miss_cnt); end
      checks++; if (hit_cnt !== 16'd3) begin errors++; $display("FAIL rep_hit_cnt: got %0d want 3", hit_cnt); end
   endtask

   task automatic test_timeout;
      bit seen = 1'b0;
      bit got = 1'b0;
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pre_clear: got %b want 0", err_timeout); end
      block_done = 1'b1;
      @(posedge clk); #1;
      if_addr = 16'h0600;
      if_req  = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk); #1;
         if (mem_rd) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL to_grant: got no mem_rd want mem_rd=1"); end
      // Now inside BUSY cycle 1; each rising edge closes one BUSY cycle.
      repeat (23) @(posedge clk);
      #1;
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0 after 23 cycles", err_timeout); end
      @(posedge clk); #1;
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_set: got %b want 1 after 24 cycles", err_timeout); end
      repeat (10) @(posedge clk);
      #1;
      checks++; if ({err_timeout, mem_rd} !== 2'b11) begin errors++; $display("FAIL to_hold: got err=%b rd=%b want 1 1", err_timeout, mem_rd); end
      block_done = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk); #1;
         if (if_done) got = 1'b1;
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      checks++; if (!got) begin errors++; $display("FAIL to_complete: got no if_done want pulse"); end
      @(negedge clk); #1;
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
   endtask

   task automatic test_reset_mid_busy;
      bit seen = 1'b0;
      int stray = 0;
      @(posedge clk); #1;
      d_wr = 1'b0; d_addr = 16'h0700;
      d_req = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk); #1;
         if (mem_rd) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL rmb_grant: got no mem_rd want mem_rd=1"); end
      #1;
      rst = 1'b0;
      #1;
      checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL rmb_async_drop: got rd/wr=%b want 00", {mem_rd, mem_wr}); end
      checks++; if (err_timeout !== 1'b0 || hit_cnt !== 16'd0 || miss_cnt !== 16'd0)
         begin errors++; $display("FAIL rmb_state_clear: got err=%b hit=%0d miss=%0d want 0 0 0", err_timeout, hit_cnt, miss_cnt); end
      d_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         if (d_done || if_done || mem_rd || mem_wr) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL rmb_lost: got %0d active cycles want 0", stray); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_stall();
      test_both_req();
      test_drop_req();
      test_repeat_hits();
      test_timeout();
      test_reset_mid_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
